// File: rtl/display_row_scanner.sv
// display_row_scanner: row/bit-plane sequencer for an LED matrix panel.
// For every scan row and every bit plane (MSB first) it reads one row of pixels
// from the frame buffer, shifts the selected bit of each channel into the panel
// column drivers, latches them, then enables the outputs while the paired pulse
// generator times a binary-weighted on-period.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   enable                     start/continue scanning (sampled in IDLE and at frame end)
//   pulse_go / pulse_complete  handshake with the pulse generator
//   pixel_col, pixel_row       frame-buffer read address (data returns one cycle later)
//   pixel_r/g/b                frame-buffer read data
//   panel_r/g/b, panel_sclk    serial column data and shift clock
//   panel_latch, panel_oe_n    latch strobe and active-low output enable
//   panel_row                  panel row select
//   frame_done                 one-cycle strobe when the last row finishes
module display_row_scanner #(
  parameter int unsigned bitwidth = 8,
  parameter int unsigned columns  = 32,
  parameter int unsigned rows     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        pulse_go,
  input  logic                        pulse_complete,
  output logic [$clog2(columns)-1:0]  pixel_col,
  output logic [$clog2(rows)-1:0]     pixel_row,
  input  logic [bitwidth-1:0]         pixel_r,
  input  logic [bitwidth-1:0]         pixel_g,
  input  logic [bitwidth-1:0]         pixel_b,
  output logic                        panel_r,
  output logic                        panel_g,
  output logic                        panel_b,
  output logic                        panel_sclk,
  output logic                        panel_latch,
  output logic                        panel_oe_n,
  output logic [$clog2(rows)-1:0]     panel_row,
  output logic                        frame_done
);

  localparam int unsigned col_w   = $clog2(columns);
  localparam int unsigned row_w   = $clog2(rows);
  localparam int unsigned plane_w = (bitwidth > 1) ? $clog2(bitwidth) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    LATCH   = 3'd2,
    DISPLAY = 3'd3,
    NEXT    = 3'd4
  } state_t;

  state_t               state, state_d;
  logic [plane_w-1:0]   plane, plane_d;
  logic [col_w-1:0]     col, col_d;
  logic                 phase, phase_d;        // 0 = phase A, 1 = phase B

  logic                 pulse_go_d, sclk_d, latch_d, oe_n_d, frame_done_d;
  logic                 r_d, g_d, b_d;
  logic [col_w-1:0]     pixel_col_d;
  logic [row_w-1:0]     pixel_row_d, panel_row_d;

  logic [plane_w-1:0]   bit_idx;
  logic                 last_col, last_plane, last_row;

  // Plane 0 drives the pixel MSB.
  assign bit_idx    = plane_w'(bitwidth - 1) - plane;
  assign last_col   = (col == col_w'(columns - 1));
  assign last_plane = (plane == plane_w'(bitwidth - 1));
  assign last_row   = (pixel_row == row_w'(rows - 1));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      plane       <= '0;
      col         <= '0;
      phase       <= 1'b0;
      pulse_go    <= 1'b0;
      panel_sclk  <= 1'b0;
      panel_latch <= 1'b0;
      panel_oe_n  <= 1'b1;
      frame_done  <= 1'b0;
      panel_r     <= 1'b0;
      panel_g     <= 1'b0;
      panel_b     <= 1'b0;
      pixel_col   <= '0;
      pixel_row   <= '0;
      panel_row   <= '0;
    end else begin
      state       <= state_d;
      plane       <= plane_d;
      col         <= col_d;
      phase       <= phase_d;
      pulse_go    <= pulse_go_d;
      panel_sclk  <= sclk_d;
      panel_latch <= latch_d;
      panel_oe_n  <= oe_n_d;
      frame_done  <= frame_done_d;
      panel_r     <= r_d;
      panel_g     <= g_d;
      panel_b     <= b_d;
      pixel_col   <= pixel_col_d;
      pixel_row   <= pixel_row_d;
      panel_row   <= panel_row_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    plane_d      = plane;
    col_d        = col;
    phase_d      = phase;
    pulse_go_d   = pulse_go;
    sclk_d       = panel_sclk;
    latch_d      = 1'b0;
    oe_n_d       = panel_oe_n;
    frame_done_d = 1'b0;
    r_d          = panel_r;
    g_d          = panel_g;
    b_d          = panel_b;
    pixel_col_d  = pixel_col;
    pixel_row_d  = pixel_row;
    panel_row_d  = panel_row;

    unique case (state)
      IDLE: begin
        oe_n_d     = 1'b1;
        pulse_go_d = 1'b0;
        sclk_d     = 1'b0;
        if (enable) begin
          state_d     = SHIFT;
          plane_d     = '0;
          col_d       = '0;
          phase_d     = 1'b0;
          pixel_col_d = '0;
        end
      end

      SHIFT: begin
        if (!phase) begin
          // Data for col arrives now (address issued two edges ago);
          // issue the next column's address.
          r_d         = pixel_r[bit_idx];
          g_d         = pixel_g[bit_idx];
          b_d         = pixel_b[bit_idx];
          sclk_d      = 1'b0;
          pixel_col_d = last_col ? '0 : col + col_w'(1);
          phase_d     = 1'b1;
        end else begin
          sclk_d  = 1'b1;
          phase_d = 1'b0;
          if (last_col) begin
            col_d       = '0;
            state_d     = LATCH;
            latch_d     = 1'b1;
            panel_row_d = pixel_row;  // outputs are still blanked here
          end else begin
            col_d = col + col_w'(1);
          end
        end
      end

      LATCH: begin
        sclk_d     = 1'b0;
        state_d    = DISPLAY;
        pulse_go_d = 1'b1;
        oe_n_d     = 1'b0;
      end

      DISPLAY: begin
        if (pulse_complete) begin
          pulse_go_d = 1'b0;
          oe_n_d     = 1'b1;
          state_d    = NEXT;
          // Advance the read row one cycle early so the first column of the
          // next row has its full read latency before SHIFT samples it.
          if (last_plane) begin
            pixel_row_d  = last_row ? '0 : pixel_row + row_w'(1);
            frame_done_d = last_row;
          end
        end
      end

      NEXT: begin
        if (!last_plane) begin
          plane_d = plane + plane_w'(1);
          state_d = SHIFT;
        end else begin
          plane_d = '0;
          // frame_done is high exactly during the NEXT that ends a frame.
          state_d = (frame_done && !enable) ? IDLE : SHIFT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_display_row_scanner.sv
// Scoreboard bench for display_row_scanner at bitwidth=2, columns=4, rows=2.
// Includes a registered frame-buffer model and a pulse-generator model whose
// on-time for plane p is 2^(bitwidth-p) cycles of pulse_go.
module tb_display_row_scanner;

  localparam int BW   = 2;
  localparam int COLS = 4;
  localparam int ROWS = 2;

  logic       clk = 1'b0;
  logic       rst, enable, spurious;
  logic       pulse_go, pulse_complete, gen_complete;
  logic [1:0] pixel_col;
  logic [0:0] pixel_row, panel_row;
  logic [BW-1:0] pixel_r, pixel_g, pixel_b;
  logic       panel_r, panel_g, panel_b, panel_sclk, panel_latch, panel_oe_n, frame_done;

  logic [BW-1:0] mem_r [ROWS][COLS];
  logic [BW-1:0] mem_g [ROWS][COLS];
  logic [BW-1:0] mem_b [ROWS][COLS];

  int exp_bits[$];
  int exp_row[$];
  int exp_len[$];
  int exp_fd[$];

  int tests = 0;
  int errors = 0;
  int fd_count = 0;

  always #5 clk = ~clk;

  display_row_scanner #(.bitwidth(BW), .columns(COLS), .rows(ROWS)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pulse_go(pulse_go), .pulse_complete(pulse_complete),
    .pixel_col(pixel_col), .pixel_row(pixel_row),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .panel_r(panel_r), .panel_g(panel_g), .panel_b(panel_b),
    .panel_sclk(panel_sclk), .panel_latch(panel_latch), .panel_oe_n(panel_oe_n),
    .panel_row(panel_row), .frame_done(frame_done)
  );

  // Frame buffer: one-cycle registered read.
  always @(posedge clk) begin
    pixel_r <= mem_r[pixel_row][pixel_col];
    pixel_g <= mem_g[pixel_row][pixel_col];
    pixel_b <= mem_b[pixel_row][pixel_col];
  end

  // Pulse generator: complete during the on-time'th cycle of pulse_go.
  logic [0:0] gen_plane;
  int gen_cnt;
  int gen_on;
  always_comb gen_on = 1 << (BW - int'(gen_plane));
  assign gen_complete   = pulse_go && (gen_cnt == gen_on - 1);
  assign pulse_complete = gen_complete | spurious;

  always @(posedge clk) begin
    if (rst) begin
      gen_cnt   <= 0;
      gen_plane <= 1'b0;
    end else if (gen_complete) begin
      gen_cnt   <= 0;
      gen_plane <= gen_plane + 1'b1;
    end else if (pulse_go) begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_plane(input int r, input int p);
    for (int c = 0; c < COLS; c++) begin
      logic [BW-1:0] vr, vg, vb;
      vr = mem_r[r][c];
      vg = mem_g[r][c];
      vb = mem_b[r][c];
      exp_bits.push_back(int'({vr[BW-1-p], vg[BW-1-p], vb[BW-1-p]}));
    end
    exp_row.push_back(r);
    exp_len.push_back(1 << (BW - p));
  endtask

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < BW; p++)
        push_plane(r, p);
    exp_fd.push_back(ROWS - 1);
  endtask

  function automatic int pending();
    return exp_bits.size() + exp_row.size() + exp_len.size() + exp_fd.size();
  endfunction

  task automatic wait_drain(input string name);
    int k = 0;
    while (pending() != 0 && k < 3000) begin
      step();
      k++;
    end
    check(name, pending(), 0);
  endtask

  // Monitor: pops expectations whenever the panel shows an event.
  initial begin : monitor
    int run = 0;
    logic prev_sclk = 1'b0;
    logic prev_cpl = 1'b0;
    int prev_rgb = 0;
    int rgb;
    forever begin
      @(negedge clk);
      rgb = int'({panel_r, panel_g, panel_b});
      if (rst) begin
        run = 0;
        prev_sclk = 1'b0;
        prev_cpl = 1'b0;
      end else begin
        if (panel_sclk && !prev_sclk) begin
          check("data_setup", rgb, prev_rgb);
          if (exp_bits.size() == 0) check("unexpected_sclk", 1, 0);
          else check("shift_bits", rgb, exp_bits.pop_front());
        end
        if (panel_latch) begin
          check("latch_blanked", int'(panel_oe_n), 1);
          if (exp_row.size() == 0) check("unexpected_latch", 1, 0);
          else check("latch_row", int'(panel_row), exp_row.pop_front());
        end
        if (!panel_oe_n) check("oe_only_in_display", int'(pulse_go), 1);
        if (prev_cpl) check("go_low_after_complete", int'(pulse_go), 0);
        if (pulse_go) run++;
        else if (run > 0) begin
          if (exp_len.size() == 0) check("unexpected_pulse", 1, 0);
          else check("on_time", run, exp_len.pop_front());
          run = 0;
        end
        if (frame_done) begin
          fd_count++;
          if (exp_fd.size() == 0) check("unexpected_frame_done", 1, 0);
          else check("frame_done_row", int'(panel_row), exp_fd.pop_front());
        end
        prev_sclk = panel_sclk;
        prev_cpl  = pulse_complete;
      end
      prev_rgb = rgb;
    end
  end

  initial begin : stimulus
    int n;
    int k;
    logic got;
    // Row 0 red is 10,01,11,00: plane 0 shifts 1,0,1,0 and plane 1 shifts 0,1,1,0.
    mem_r[0] = '{2'b10, 2'b01, 2'b11, 2'b00};
    mem_g[0] = '{2'b11, 2'b11, 2'b00, 2'b00};
    mem_b[0] = '{2'b00, 2'b10, 2'b10, 2'b01};
    mem_r[1] = '{2'b00, 2'b11, 2'b01, 2'b10};
    mem_g[1] = '{2'b01, 2'b00, 2'b01, 2'b00};
    mem_b[1] = '{2'b10, 2'b10, 2'b11, 2'b11};
    rst = 1'b1;
    enable = 1'b0;
    spurious = 1'b0;
    repeat (3) step();

    // Reset values.
    check("rst_pulse_go", int'(pulse_go), 0);
    check("rst_sclk", int'(panel_sclk), 0);
    check("rst_latch", int'(panel_latch), 0);
    check("rst_oe_n", int'(panel_oe_n), 1);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_rgb", int'({panel_r, panel_g, panel_b}), 0);
    check("rst_pixel_col", int'(pixel_col), 0);
    check("rst_pixel_row", int'(pixel_row), 0);
    check("rst_panel_row", int'(panel_row), 0);
    rst = 1'b0;
    repeat (3) step();
    check("idle_oe_n", int'(panel_oe_n), 1);
    check("idle_no_sclk", int'(panel_sclk), 0);

    // Two frames; a stray complete during SHIFT must be ignored.
    push_frame();
    push_frame();
    enable = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      spurious = (n == 3);
      if (panel_latch) got = 1'b1;
    end
    spurious = 1'b0;
    check("first_latch_cycle", n, 9);

    // Drop enable during row 0 of the second frame; the frame must finish.
    k = 0;
    while (exp_row.size() > 3 && k < 2000) begin
      step();
      k++;
    end
    check("reach_frame2_row0", int'(k < 2000), 1);
    enable = 1'b0;
    wait_drain("two_frames_drain");
    repeat (20) step();
    check("frames_done_count", fd_count, 2);
    check("idle_after_frame_go", int'(pulse_go), 0);
    check("idle_after_frame_oe_n", int'(panel_oe_n), 1);
    check("idle_after_frame_pixel_row", int'(pixel_row), 0);
    check("idle_keeps_panel_row", int'(panel_row), 1);

    // Reset during DISPLAY of plane 1 on row 0.
    push_plane(0, 0);
    push_plane(0, 1);
    enable = 1'b1;
    step();
    enable = 1'b0;
    k = 0;
    while (exp_row.size() != 0 && k < 2000) begin
      step();
      k++;
    end
    check("reach_plane1_latch", int'(k < 2000), 1);
    k = 0;
    while (!pulse_go && k < 20) begin
      step();
      k++;
    end
    check("plane1_go_seen", int'(pulse_go), 1);
    step();
    rst = 1'b1;
    step();
    check("mid_rst_go", int'(pulse_go), 0);
    check("mid_rst_oe_n", int'(panel_oe_n), 1);
    check("mid_rst_latch", int'(panel_latch), 0);
    check("mid_rst_panel_row", int'(panel_row), 0);
    exp_bits.delete();
    exp_row.delete();
    exp_len.delete();
    exp_fd.delete();
    step();
    rst = 1'b0;
    step();

    // Restart: row 0 plane 0 at full on-time, whole frame completes.
    push_frame();
    enable = 1'b1;
    step();
    enable = 1'b0;
    wait_drain("restart_frame_drain");
    repeat (10) step();
    check("restart_frames_done_count", fd_count, 3);
    check("restart_idle_go", int'(pulse_go), 0);
    check("restart_idle_oe_n", int'(panel_oe_n), 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
